// File: rtl/dot_product_n_if.sv
// Vector-pair input / scalar result bundle for dot_product_n.
// The producer side (master) drives the vector pair, the datapath (slave)
// returns the result with its valid flag.
interface dot_product_n_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  logic                 valid_in;
  logic [N*WIDTH-1:0]   x_in;
  logic [N*WIDTH-1:0]   y_in;
  logic                 valid_out;
  logic [WIDTH-1:0]     out;

  modport master (
    output valid_in,
    output x_in,
    output y_in,
    input  valid_out,
    input  out
  );

  modport slave (
    input  valid_in,
    input  x_in,
    input  y_in,
    output valid_out,
    output out
  );
endinterface

// File: rtl/dot_product_n.sv
// Fully pipelined signed N-element dot product.
// Stages: per-element multiply, per-term arithmetic scaling, a registered
// binary adder tree (one level per stage, zero-padded to a power of two),
// then saturate/wrap reduction to WIDTH. One pair accepted every cycle,
// results in order after 3 + clog2(N) cycles. Data registers run freely;
// only the valid shift register qualifies the output.
module dot_product_n #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 0,
  parameter int SATURATE  = 0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  dot_product_n_if.slave io_bus
);

  // Tree depth, padded leaf count, accumulator width and total latency.
  // ACC carries clog2(N) guard bits above the 2*WIDTH product so the
  // tree can never overflow.
  localparam int LVL = $clog2(N);
  localparam int NP  = 1 << LVL;
  localparam int ACC = 2 * WIDTH + LVL;
  localparam int LAT = 3 + LVL;

  logic signed [2*WIDTH-1:0] w_x_ext  [N];
  logic signed [2*WIDTH-1:0] w_y_ext  [N];
  logic signed [ACC-1:0]     w_scaled [N];

  logic signed [2*WIDTH-1:0] r_prod [N];
  // Heap-ordered tree: leaves at NP..2*NP-1, node k sums nodes 2k and 2k+1,
  // root at index 1. With N = 1 the single leaf is also the root.
  logic signed [ACC-1:0]     r_node [1:2*NP-1];
  logic [LAT-1:0]            r_valid;
  logic [WIDTH-1:0]          r_out;

  logic signed [ACC-1:0]     w_sum;
  logic signed [ACC-1:0]     w_hi;
  logic signed [ACC-1:0]     w_lo;
  logic [WIDTH-1:0]          w_reduced;

  // Sign-extend each input element to product width so the multiply is exact.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_x_ext[i] = {{WIDTH{io_bus.x_in[i*WIDTH+WIDTH-1]}}, io_bus.x_in[i*WIDTH +: WIDTH]};
      w_y_ext[i] = {{WIDTH{io_bus.y_in[i*WIDTH+WIDTH-1]}}, io_bus.y_in[i*WIDTH +: WIDTH]};
    end
  end

  // Widen each product to ACC and scale it; >>> on a signed value floors toward -inf.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_scaled[i] = $signed(ACC'(r_prod[i])) >>> FRAC_BITS;
    end
  end

  // Stage 1: element-wise full-precision products.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        r_prod[i] <= {(2*WIDTH){1'b0}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_prod[i] <= w_x_ext[i] * w_y_ext[i];
      end
    end
  end

  // Stage 2 (leaves) and adder-tree levels; all nodes shift forward together.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 1; k < 2 * NP; k++) begin
        r_node[k] <= {ACC{1'b0}};
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (i < N) begin
          r_node[NP+i] <= w_scaled[i];
        end else begin
          r_node[NP+i] <= {ACC{1'b0}};
        end
      end
      for (int k = 1; k < NP; k++) begin
        r_node[k] <= r_node[2*k] + r_node[2*k+1];
      end
    end
  end

  // Reduce the ACC-wide sum to WIDTH: clamp when saturating, else keep low bits.
  always_comb begin
    w_sum = r_node[1];
    w_hi  = {{(ACC-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    w_lo  = {{(ACC-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    if ((SATURATE != 0) && (w_sum > w_hi)) begin
      w_reduced = {1'b0, {(WIDTH-1){1'b1}}};
    end else if ((SATURATE != 0) && (w_sum < w_lo)) begin
      w_reduced = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      w_reduced = w_sum[WIDTH-1:0];
    end
  end

  // Output stage register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_out <= {WIDTH{1'b0}};
    end else begin
      r_out <= w_reduced;
    end
  end

  // Valid shift register, LAT deep, aligned with the data pipeline.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= {LAT{1'b0}};
    end else begin
      r_valid <= {r_valid[LAT-2:0], io_bus.valid_in};
    end
  end

  assign io_bus.out       = r_out;
  assign io_bus.valid_out = r_valid[LAT-1];

endmodule

// File: tb/tb_dot_product_n.sv
// Directed self-checking bench for dot_product_n. Five instances cover the
// fixed-point, saturating, wrapping, streaming (N=3) and degenerate (N=1)
// configurations; all share one clock and reset.
module tb_dot_product_n;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dot_product_n_if #(.N(4), .WIDTH(32)) if_a ();
  dot_product_n_if #(.N(4), .WIDTH(16)) if_b ();
  dot_product_n_if #(.N(4), .WIDTH(16)) if_c ();
  dot_product_n_if #(.N(3), .WIDTH(32)) if_d ();
  dot_product_n_if #(.N(1), .WIDTH(8))  if_e ();

  // Q16.16, wrap
  dot_product_n #(.N(4), .WIDTH(32), .FRAC_BITS(16), .SATURATE(0)) u_a (
    .clk_in(clk), .rst_in(rst), .io_bus(if_a));
  // integer 16-bit, saturate
  dot_product_n #(.N(4), .WIDTH(16), .FRAC_BITS(0), .SATURATE(1)) u_b (
    .clk_in(clk), .rst_in(rst), .io_bus(if_b));
  // integer 16-bit, wrap
  dot_product_n #(.N(4), .WIDTH(16), .FRAC_BITS(0), .SATURATE(0)) u_c (
    .clk_in(clk), .rst_in(rst), .io_bus(if_c));
  // N=3 integer, latency 5
  dot_product_n #(.N(3), .WIDTH(32), .FRAC_BITS(0), .SATURATE(0)) u_d (
    .clk_in(clk), .rst_in(rst), .io_bus(if_d));
  // N=1, latency 3
  dot_product_n #(.N(1), .WIDTH(8), .FRAC_BITS(0), .SATURATE(0)) u_e (
    .clk_in(clk), .rst_in(rst), .io_bus(if_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_a.valid_in = 1'b1;  // must be ignored while in reset
    if_a.x_in = 128'(32'h0001_0000);
    if_a.y_in = 128'(32'h0001_0000);
    tick();
    tick();
    if_a.valid_in = 1'b0;
    if_a.x_in = 128'd0;
    if_a.y_in = 128'd0;
    total++; if (if_a.valid_out !== 1'b0) begin bad++; $display("FAIL reset_a_valid: got %b expected 0", if_a.valid_out); end
    total++; if (if_a.out !== 32'h0) begin bad++; $display("FAIL reset_a_out: got %h expected 0", if_a.out); end
    total++; if (if_b.valid_out !== 1'b0 || if_b.out !== 16'h0) begin bad++; $display("FAIL reset_b: got v=%b out=%h expected v=0 out=0", if_b.valid_out, if_b.out); end
    total++; if (if_c.valid_out !== 1'b0 || if_c.out !== 16'h0) begin bad++; $display("FAIL reset_c: got v=%b out=%h expected v=0 out=0", if_c.valid_out, if_c.out); end
    total++; if (if_d.valid_out !== 1'b0 || if_d.out !== 32'h0) begin bad++; $display("FAIL reset_d: got v=%b out=%h expected v=0 out=0", if_d.valid_out, if_d.out); end
    total++; if (if_e.valid_out !== 1'b0 || if_e.out !== 8'h0) begin bad++; $display("FAIL reset_e: got v=%b out=%h expected v=0 out=0", if_e.valid_out, if_e.out); end
    rst = 1'b0;
    idle(6);
    total++; if (if_a.valid_out !== 1'b0) begin bad++; $display("FAIL reset_a_no_emit: got %b expected 0", if_a.valid_out); end
  endtask

  // 1.0 * 2.5 in Q16.16 -> 2.5, valid exactly after the 5th edge
  task automatic test_fixed_point();
    if_a.valid_in = 1'b1;
    if_a.x_in = {96'd0, 32'h0001_0000};
    if_a.y_in = {96'd0, 32'h0002_8000};
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 1) begin
        if_a.valid_in = 1'b0;
        if_a.x_in = 128'd0;
        if_a.y_in = 128'd0;
      end
      total++;
      if (if_a.valid_out !== (e == 5)) begin
        bad++; $display("FAIL fixed_valid_e%0d: got %b expected %b", e, if_a.valid_out, (e == 5));
      end
      if (e == 5) begin
        total++;
        if (if_a.out !== 32'h0002_8000) begin bad++; $display("FAIL fixed_out: got %h expected 00028000", if_a.out); end
      end
    end
  endtask

  // -1 LSB * 1 LSB scaled by 2^-16 floors to -1 LSB, not 0
  task automatic test_neg_floor();
    if_a.valid_in = 1'b1;
    if_a.x_in = {96'd0, 32'hFFFF_FFFF};
    if_a.y_in = {96'd0, 32'h0000_0001};
    tick();
    if_a.valid_in = 1'b0;
    if_a.x_in = 128'd0;
    if_a.y_in = 128'd0;
    idle(4);
    total++;
    if (if_a.valid_out !== 1'b1 || if_a.out !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL neg_floor: got v=%b out=%h expected v=1 out=ffffffff", if_a.valid_out, if_a.out);
    end
  endtask

  task automatic test_saturation();
    if_b.valid_in = 1'b1;
    if_c.valid_in = 1'b1;
    if_b.x_in = {4{16'h7FFF}};
    if_b.y_in = {4{16'h7FFF}};
    if_c.x_in = {4{16'h7FFF}};
    if_c.y_in = {4{16'h7FFF}};
    tick();
    if_b.x_in = {4{16'h8000}};
    if_b.y_in = {4{16'h7FFF}};
    if_c.x_in = {4{16'h8000}};
    if_c.y_in = {4{16'h7FFF}};
    tick();
    if_b.valid_in = 1'b0;
    if_c.valid_in = 1'b0;
    if_b.x_in = 64'd0; if_b.y_in = 64'd0;
    if_c.x_in = 64'd0; if_c.y_in = 64'd0;
    idle(3);
    // first pair: sum 0xFFFC0004
    total++; if (if_b.valid_out !== 1'b1 || if_b.out !== 16'h7FFF) begin bad++; $display("FAIL sat_pos: got v=%b out=%h expected v=1 out=7fff", if_b.valid_out, if_b.out); end
    total++; if (if_c.valid_out !== 1'b1 || if_c.out !== 16'h0004) begin bad++; $display("FAIL wrap_pos: got v=%b out=%h expected v=1 out=0004", if_c.valid_out, if_c.out); end
    tick();
    // second pair: sum -0xFFFE0000
    total++; if (if_b.valid_out !== 1'b1 || if_b.out !== 16'h8000) begin bad++; $display("FAIL sat_neg: got v=%b out=%h expected v=1 out=8000", if_b.valid_out, if_b.out); end
    total++; if (if_c.valid_out !== 1'b1 || if_c.out !== 16'h0000) begin bad++; $display("FAIL wrap_neg: got v=%b out=%h expected v=1 out=0000", if_c.valid_out, if_c.out); end
    tick();
    total++; if (if_b.valid_out !== 1'b0) begin bad++; $display("FAIL sat_tail_valid: got %b expected 0", if_b.valid_out); end
  endtask

  // N=3: 8 back-to-back pairs, 2-cycle gap, 2 more; out = 6k
  task automatic test_back_to_back();
    bit vin [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int kv  [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 8, 9};
    for (int c = 0; c < 12 + 5 + 2; c++) begin
      int  j;
      bit  exp_v;
      if (c < 12) begin
        if_d.valid_in = vin[c];
        if_d.x_in = {32'(kv[c]), 32'(kv[c]), 32'(kv[c])};
        if_d.y_in = {32'd3, 32'd2, 32'd1};
      end else begin
        if_d.valid_in = 1'b0;
        if_d.x_in = 96'd0;
        if_d.y_in = 96'd0;
      end
      tick();
      j = c - 4;
      exp_v = (j >= 0 && j < 12) ? vin[j] : 1'b0;
      total++;
      if (if_d.valid_out !== exp_v) begin
        bad++; $display("FAIL stream_valid_c%0d: got %b expected %b", c, if_d.valid_out, exp_v);
      end
      if (exp_v) begin
        total++;
        if (if_d.out !== 32'(6 * kv[j])) begin
          bad++; $display("FAIL stream_out_k%0d: got %0d expected %0d", kv[j], if_d.out, 6 * kv[j]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int p = 0; p < 3; p++) begin
      if_a.valid_in = 1'b1;
      if_a.x_in = 128'(32'h0001_0000 * (p + 1));
      if_a.y_in = 128'(32'h0001_0000);
      tick();
    end
    rst = 1'b1;
    if_a.x_in = 128'(32'h0007_0000);  // valid_in still high: ignored
    tick();
    total++;
    if (if_a.valid_out !== 1'b0 || if_a.out !== 32'h0) begin
      bad++; $display("FAIL midrst_clear: got v=%b out=%h expected v=0 out=0", if_a.valid_out, if_a.out);
    end
    rst = 1'b0;
    if_a.valid_in = 1'b1;
    if_a.x_in = 128'(32'h0005_0000);
    if_a.y_in = 128'(32'h0001_0000);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) begin
        if_a.valid_in = 1'b0;
        if_a.x_in = 128'd0;
        if_a.y_in = 128'd0;
      end
      total++;
      if (if_a.valid_out !== (e == 5)) begin
        bad++; $display("FAIL midrst_valid_e%0d: got %b expected %b", e, if_a.valid_out, (e == 5));
      end
      total++;
      if (if_a.out !== ((e == 5) ? 32'h0005_0000 : 32'h0)) begin
        bad++; $display("FAIL midrst_out_e%0d: got %h expected %h", e, if_a.out, ((e == 5) ? 32'h0005_0000 : 32'h0));
      end
    end
  endtask

  // N=1: -3 * 5 = -15 after 3 edges
  task automatic test_degenerate();
    if_e.valid_in = 1'b1;
    if_e.x_in = 8'hFD;
    if_e.y_in = 8'h05;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 1) begin
        if_e.valid_in = 1'b0;
        if_e.x_in = 8'h00;
        if_e.y_in = 8'h00;
      end
      total++;
      if (if_e.valid_out !== (e == 3)) begin
        bad++; $display("FAIL n1_valid_e%0d: got %b expected %b", e, if_e.valid_out, (e == 3));
      end
      if (e == 3) begin
        total++;
        if (if_e.out !== 8'hF1) begin bad++; $display("FAIL n1_out: got %h expected f1", if_e.out); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if_a.valid_in = 1'b0; if_a.x_in = 128'd0; if_a.y_in = 128'd0;
    if_b.valid_in = 1'b0; if_b.x_in = 64'd0;  if_b.y_in = 64'd0;
    if_c.valid_in = 1'b0; if_c.x_in = 64'd0;  if_c.y_in = 64'd0;
    if_d.valid_in = 1'b0; if_d.x_in = 96'd0;  if_d.y_in = 96'd0;
    if_e.valid_in = 1'b0; if_e.x_in = 8'd0;   if_e.y_in = 8'd0;
    #1;
    test_reset();
    test_fixed_point();
    idle(2);
    test_neg_floor();
    idle(3);
    test_saturation();
    idle(2);
    test_back_to_back();
    idle(2);
    test_reset_midstream();
    idle(2);
    test_degenerate();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
